fork_join_sched: RTL and testbench

FORK_JOIN_SCHED -- requirements
Module: fork_join_sched

---
 rtl/fj_pkg.sv | 19 +
 rtl/fj_task_timer.sv | 48 ++++
 rtl/fork_join_sched.sv | 101 ++++++++++
 tb/tb_fork_join_sched.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fj_pkg.sv
// fj_pkg: shared types for the fork/join scheduler.
//   state_e : scheduler FSM states (IDLE, WAIT, JOINED)
//   mode_e  : join policy encodings; 2'b11 behaves like join_all
package fj_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    WAIT   = 2'b01,
    JOINED = 2'b10
  } state_e;

  typedef enum logic [1:0] {
    JOIN_ALL     = 2'b00,
    JOIN_ANY     = 2'b01,
    JOIN_NONE    = 2'b10,
    JOIN_ALL_ALT = 2'b11
  } mode_e;

endpackage

// File: rtl/fj_task_timer.sv
// fj_task_timer: one down-counting task timer.
//   clk, rst_n : clock, async active-low reset
//   load       : latch delay and start running
//   delay      : delay in cycles (0 completes on the first edge after load)
//   kill       : abort silently (no done pulse), highest priority
//   active     : timer running
//   done       : one-cycle completion pulse, raised on the edge that clears active
module fj_task_timer #(
  parameter int DLY_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DLY_W-1:0] delay,
  input  logic             kill,
  output logic             active,
  output logic             done
);

  logic [DLY_W-1:0] cnt;

  // Counter only decrements while nonzero, so it never wraps and a
  // full-scale delay takes exactly 2^DLY_W-1 extra cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (kill) begin
        cnt    <= '0;
        active <= 1'b0;
      end else if (load) begin
        cnt    <= delay;
        active <= 1'b1;
      end else if (active) begin
        if (cnt == '0) begin
          active <= 1'b0;
          done   <= 1'b1;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fork_join_sched.sv
// fork_join_sched: forks N_TASKS timers on start and signals the join
// according to the latched policy.
//   clk, rst_n  : clock, async active-low reset
//   start       : fork request
//   mode        : 00 join_all, 01 join_any, 10 join_none, 11 join_all
//   delay_i     : per-task delays, task i at [i*DLY_W +: DLY_W]
//   busy        : FSM not IDLE
//   task_active : per-task running flags
//   task_done   : per-task completion pulses
//   join_done   : one pulse per accepted fork
//   start_err   : pulse one cycle after a rejected start
//   kill        : (only when FJ_DISABLE_EN is defined) abort the fork
module fork_join_sched
  import fj_pkg::*;
#(
  parameter int N_TASKS = 3,
  parameter int DLY_W   = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [1:0]               mode,
  input  logic [N_TASKS*DLY_W-1:0] delay_i,
`ifdef FJ_DISABLE_EN
  input  logic                     kill,
`endif
  output logic                     busy,
  output logic [N_TASKS-1:0]       task_active,
  output logic [N_TASKS-1:0]       task_done,
  output logic                     join_done,
  output logic                     start_err
);

  state_e state, state_n;
  mode_e  mode_q;
  logic   fresh;     // high only in the cycle right after the accepting edge
  logic   can_start;
  logic   accept;
  logic   join_hit;
  logic   kill_w;

`ifdef FJ_DISABLE_EN
  assign kill_w = kill;
`else
  assign kill_w = 1'b0;
`endif

  assign can_start = (state == IDLE) && (task_active == '0);
  assign accept    = start && can_start && !kill_w;
  assign busy      = (state != IDLE);

  for (genvar i = 0; i < N_TASKS; i++) begin : g_task
    fj_task_timer #(.DLY_W(DLY_W)) u_timer (
      .clk    (clk),
      .rst_n  (rst_n),
      .load   (accept),
      .delay  (delay_i[i*DLY_W +: DLY_W]),
      .kill   (kill_w),
      .active (task_active[i]),
      .done   (task_done[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= JOIN_ALL;
      fresh     <= 1'b0;
      start_err <= 1'b0;
    end else begin
      state     <= state_n;
      fresh     <= accept;
      start_err <= start && !can_start;
      if (accept) mode_q <= mode_e'(mode);
    end
  end

  // join_done is decoded from registered state and timer outputs so it
  // lines up with the task_done pulse that satisfies the policy.
  always_comb begin
    state_n   = state;
    join_done = 1'b0;
    join_hit  = 1'b0;
    case (mode_q)
      JOIN_ANY:  join_hit = |task_done;
      JOIN_NONE: join_hit = !fresh;
      default:   join_hit = (task_active == '0);
    endcase
    case (state)
      IDLE:    if (accept) state_n = WAIT;
      WAIT:    if (join_hit) begin
                 join_done = 1'b1;
                 state_n   = JOINED;
               end
      JOINED:  if (task_active == '0) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill_w) state_n = IDLE;
  end

endmodule

// File: tb/tb_fork_join_sched.sv
module tb_fork_join_sched;
  localparam int NT = 3;
  localparam int DW = 8;
  localparam int OW = 2*NT+3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [NT*DW-1:0] delay_i = '0;
`ifdef FJ_DISABLE_EN
  logic kill = 1'b0;
`endif
  logic busy, join_done, start_err;
  logic [NT-1:0] task_active, task_done;

  always #5 clk = ~clk;

  fork_join_sched #(.N_TASKS(NT), .DLY_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .delay_i(delay_i),
`ifdef FJ_DISABLE_EN
    .kill(kill),
`endif
    .busy(busy), .task_active(task_active), .task_done(task_done),
    .join_done(join_done), .start_err(start_err)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;

  // Reference model: absolute cycle numbers of every event of the current fork.
  bit fk = 1'b0;
  int k = 0;
  int done_c[NT];
  int act_end[NT];
  int join_c = -1;
  int idle_c = -1;
  int err_c = -1;

  task automatic chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic model_edge(int e, bit s, bit [1:0] m, logic [NT*DW-1:0] d, bit kl);
    int c, mx, mn, dv;
    bit bsy;
    c = e - 1;
    bsy = fk && (c < idle_c);
    if (s && bsy) err_c = e;
    if (kl && bsy) begin
      for (int i = 0; i < NT; i++) begin
        if (act_end[i] > e) act_end[i] = e;
        if (done_c[i] >= e) done_c[i] = -1;
      end
      if (join_c >= e) join_c = -1;
      idle_c = e;
    end else if (s && !bsy && !kl) begin
      fk = 1'b1;
      k = e;
      mx = 0;
      mn = 1 << DW;
      for (int i = 0; i < NT; i++) begin
        dv = int'(d[i*DW +: DW]);
        done_c[i] = e + 1 + dv;
        act_end[i] = done_c[i];
        if (dv > mx) mx = dv;
        if (dv < mn) mn = dv;
      end
      case (m)
        2'b01:   join_c = e + 1 + mn;
        2'b10:   join_c = e + 1;
        default: join_c = e + 1 + mx;
      endcase
      idle_c = (e + 1 + mx > join_c) ? e + 2 + mx : join_c + 2;
    end
  endtask

  function automatic logic [OW-1:0] expv(int c);
    logic [NT-1:0] a, dn;
    for (int i = 0; i < NT; i++) begin
      dn[i] = fk && (c == done_c[i]);
      a[i]  = fk && (c >= k) && (c < act_end[i]);
    end
    return {fk && (c >= k) && (c < idle_c), a, dn, fk && (c == join_c), c == err_c};
  endfunction

  function automatic logic [NT*DW-1:0] rnd_d();
    logic [NT*DW-1:0] d;
    for (int i = 0; i < NT; i++) d[i*DW +: DW] = DW'($urandom_range(0, 12));
    return d;
  endfunction

  task automatic tick(bit s, bit [1:0] m, logic [NT*DW-1:0] d, bit kl);
    logic [OW-1:0] act, exp;
    start = s;
    mode = m;
    delay_i = d;
`ifdef FJ_DISABLE_EN
    kill = kl;
`endif
    @(posedge clk);
    cyc++;
    model_edge(cyc, s, m, d, kl);
    @(negedge clk);
    act = {busy, task_active, task_done, join_done, start_err};
    exp = expv(cyc);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL cyc%0d outputs: got %b want %b (busy,active,done,join,err)", cyc, act, exp);
    end
    start = 1'b0;
`ifdef FJ_DISABLE_EN
    kill = 1'b0;
`endif
  endtask

  typedef struct {
    int d0, d1, d2;
    bit [1:0] m;
    int restart, kill_at;
    int join_e, njoin, dn0, dn1, dn2, idle_e, err_e;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t t;
    int k0, rc, join_o, nj, idle_o, err_o, nd;
    int done_o[NT];

    // cycle numbers below are relative to the accepting edge
    tbl.push_back('{30, 15, 10, 2'b01,  0, 0,  11, 1, 31, 16, 11,  32, -1});
    tbl.push_back('{30, 15, 10, 2'b00,  0, 0,  31, 1, 31, 16, 11,  33, -1});
    tbl.push_back('{ 5,  5,  0, 2'b10,  0, 0,   1, 1,  6,  6,  1,   7, -1});
    tbl.push_back('{30, 15, 10, 2'b01, 21, 0,  11, 1, 31, 16, 11,  32, 21});
    tbl.push_back('{255,255,255,2'b00,  0, 0, 256, 1,256,256,256, 258, -1});
    tbl.push_back('{ 0,  0,  0, 2'b11,  0, 0,   1, 1,  1,  1,  1,   3, -1});
    tbl.push_back('{ 4,  4,  9, 2'b01,  0, 0,   5, 1,  5,  5, 10,  11, -1});
    tbl.push_back('{ 0,  0,  0, 2'b01,  0, 0,   1, 1,  1,  1,  1,   3, -1});
`ifdef FJ_DISABLE_EN
    tbl.push_back('{30, 15, 10, 2'b00,  0, 13, -1, 0, -1, -1, 11,  13, -1});
`endif

    #1 rst_n = 1'b0;
    #2;
    chk("reset_outputs", int'({busy, task_active, task_done, join_done, start_err}), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[v]) begin
      t = tbl[v];
      tick(1'b1, t.m, {DW'(t.d2), DW'(t.d1), DW'(t.d0)}, 1'b0);
      k0 = cyc;
      join_o = -1; nj = 0; idle_o = -1; err_o = -1;
      for (int i = 0; i < NT; i++) done_o[i] = -1;
      for (int r = 1; r <= 400 && !(idle_o >= 0 && r > t.restart + 1); r++) begin
        // mode/delay keep changing after the fork; they must be ignored
        tick(r == t.restart, 2'($urandom_range(0, 3)), rnd_d(), r == t.kill_at);
        rc = cyc - k0;
        if (join_done) begin
          if (join_o < 0) join_o = rc;
          nj++;
        end
        for (int i = 0; i < NT; i++) if (task_done[i] && done_o[i] < 0) done_o[i] = rc;
        if (!busy && idle_o < 0) idle_o = rc;
        if (start_err && err_o < 0) err_o = rc;
      end
      chk($sformatf("v%0d join_cycle", v), join_o, t.join_e);
      chk($sformatf("v%0d join_count", v), nj, t.njoin);
      chk($sformatf("v%0d done0", v), done_o[0], t.dn0);
      chk($sformatf("v%0d done1", v), done_o[1], t.dn1);
      chk($sformatf("v%0d done2", v), done_o[2], t.dn2);
      chk($sformatf("v%0d idle", v), idle_o, t.idle_e);
      chk($sformatf("v%0d start_err", v), err_o, t.err_e);
    end

    // reset in the middle of a long join_all fork
    tick(1'b1, 2'b00, {NT{8'hFF}}, 1'b0);
    for (int r = 1; r < 100; r++) tick(1'b0, 2'b00, rnd_d(), 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", int'({busy, task_active, task_done, join_done, start_err}), 0);
    fk = 1'b0;
    err_c = -1;
    #1 rst_n = 1'b1;
    nj = 0; nd = 0;
    for (int r = 0; r < 300; r++) begin
      tick(1'b0, 2'b00, rnd_d(), 1'b0);
      nj += int'(join_done);
      nd += int'(|task_done);
    end
    chk("post_reset_join_pulses", nj, 0);
    chk("post_reset_done_pulses", nd, 0);

    // random traffic against the model
    for (int r = 0; r < 2500; r++) begin
      bit s, kl;
      s = ($urandom_range(0, 5) == 0);
      kl = 1'b0;
`ifdef FJ_DISABLE_EN
      kl = !s && ($urandom_range(0, 30) == 0);
`endif
      tick(s, 2'($urandom_range(0, 3)), rnd_d(), kl);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
